// File: rtl/cross_comm_engine_if.sv
// Request/result handshake bundle for cross_comm_engine.
// Operands are packed per leg, with leg 0 in the least significant slice.
interface cross_comm_engine_if #(
  parameter int N_LEGS  = 4,
  parameter int RATE_W  = 16,
  parameter int RATIO_W = 8,
  parameter int PCT_W   = 8,
  parameter int OUT_W   = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [N_LEGS*RATE_W-1:0]  outright_rate;
  logic [N_LEGS*RATIO_W-1:0] ratio;
  logic [PCT_W-1:0]          inter_rate;
  logic                      out_valid;
  logic                      out_ready;
  logic [OUT_W-1:0]          cross_comm_charge;
  logic                      overflow;

  modport master (
    output in_valid, outright_rate, ratio, inter_rate, out_ready,
    input  in_ready, out_valid, cross_comm_charge, overflow
  );

  modport slave (
    input  in_valid, outright_rate, ratio, inter_rate, out_ready,
    output in_ready, out_valid, cross_comm_charge, overflow
  );
endinterface

// File: rtl/cross_comm_engine.sv
// Cross-commodity charge: sum(rate*ratio)*inter_rate/PCT_BASE, serial divide.
// Optional macro CROSS_COMM_SAT_EN saturates the charge on overflow.
module cross_comm_engine #(
  parameter int N_LEGS   = 4,
  parameter int RATE_W   = 16,
  parameter int RATIO_W  = 8,
  parameter int PCT_W    = 8,
  parameter int PCT_BASE = 100,
  parameter int OUT_W    = 16
) (
  input logic clk,
  input logic reset,
  cross_comm_engine_if.slave bus
);
  localparam int ACC_W  = RATE_W + RATIO_W + $clog2(N_LEGS);
  localparam int PROD_W = ACC_W + PCT_W;
  localparam int IDX_W  = (N_LEGS > 1) ? $clog2(N_LEGS) : 1;
  localparam int CNT_W  = $clog2(PROD_W);
  localparam int REM_W  = PCT_W + 1;
  localparam int TRL_W  = REM_W + 1;
  localparam int QX_W   = PROD_W + OUT_W;

  typedef enum logic [2:0] {
    IDLE, ACCUM, SCALE, DIV, DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [N_LEGS*RATE_W-1:0]   rates_q, rates_d;
  logic [N_LEGS*RATIO_W-1:0]  ratios_q, ratios_d;
  logic [PCT_W-1:0]           pct_q, pct_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [PROD_W-1:0]          prod_q, prod_d;
  logic [REM_W-1:0]           rem_q, rem_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       rdy_q, rdy_d;
  logic                       vld_q, vld_d;
  logic [OUT_W-1:0]           chg_q, chg_d;
  logic                       ovf_q, ovf_d;

  logic [RATE_W-1:0]  leg_rate;
  logic [RATIO_W-1:0] leg_ratio;
  logic [ACC_W-1:0]   leg_term;
  logic [TRL_W-1:0]   trial;
  logic [TRL_W-1:0]   base_w;
  logic               qbit;
  logic [PROD_W-1:0]  quot;
  logic [QX_W-1:0]    q_ext;
  logic               q_ovf;
  logic [OUT_W-1:0]   q_chg;

  assign leg_rate  = rates_q[idx_q*RATE_W +: RATE_W];
  assign leg_ratio = ratios_q[idx_q*RATIO_W +: RATIO_W];
  assign leg_term  = ACC_W'(leg_rate) * ACC_W'(leg_ratio);

  // prod_q shifts out dividend bits at the top and quotient bits in below
  assign base_w = TRL_W'(PCT_BASE);
  assign trial  = {rem_q, prod_q[PROD_W-1]};
  assign qbit   = (trial >= base_w);
  assign quot   = {prod_q[PROD_W-2:0], qbit};
  assign q_ext  = QX_W'(quot);
  assign q_ovf  = |(q_ext >> OUT_W);

`ifdef CROSS_COMM_SAT_EN
  assign q_chg = q_ovf ? '1 : q_ext[OUT_W-1:0];
`else
  assign q_chg = q_ext[OUT_W-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    rates_d  = rates_q;
    ratios_d = ratios_q;
    pct_d    = pct_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    rdy_d    = rdy_q;
    vld_d    = vld_q;
    chg_d    = chg_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          rates_d  = bus.outright_rate;
          ratios_d = bus.ratio;
          pct_d    = bus.inter_rate;
          acc_d    = '0;
          idx_d    = '0;
          rdy_d    = 1'b0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + leg_term;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N_LEGS - 1)) state_d = SCALE;
      end
      SCALE: begin
        prod_d  = PROD_W'(acc_q) * PROD_W'(pct_q);
        rem_d   = '0;
        cnt_d   = CNT_W'(PROD_W - 1);
        state_d = DIV;
      end
      DIV: begin
        rem_d  = REM_W'(qbit ? (trial - base_w) : trial);
        prod_d = quot;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          vld_d   = 1'b1;
          chg_d   = q_chg;
          ovf_d   = q_ovf;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          vld_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rates_q  <= '0;
      ratios_q <= '0;
      pct_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b1;
      vld_q    <= 1'b0;
      chg_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rates_q  <= rates_d;
      ratios_q <= ratios_d;
      pct_q    <= pct_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
      vld_q    <= vld_d;
      chg_q    <= chg_d;
      ovf_q    <= ovf_d;
    end
  end

  // Held low throughout reset, not just after the first reset edge
  assign bus.in_ready          = rdy_q & ~reset;
  assign bus.out_valid         = vld_q;
  assign bus.cross_comm_charge = chg_q;
  assign bus.overflow          = ovf_q;
endmodule

// File: tb/tb_cross_comm_engine.sv
// Directed and random checks of cross_comm_engine against an arithmetic model.
// Expected charge follows CROSS_COMM_SAT_EN when the macro is defined.
module tb_cross_comm_engine;
  localparam longint BASE = 100;
  localparam int     LAT  = 39;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cross_comm_engine_if m_if ();
  cross_comm_engine_if #(.N_LEGS(1), .PCT_W(10)) s_if ();

  cross_comm_engine u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m_if.slave)
  );

  cross_comm_engine #(.N_LEGS(1), .PCT_W(10), .PCT_BASE(1000)) u_swp (
    .clk   (clk),
    .reset (reset),
    .bus   (s_if.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint model_q(input logic [63:0] r,
                                     input logic [31:0] ra,
                                     input logic [7:0] ir);
    longint sum = 0;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] rv = r[i*16 +: 16];
      logic [7:0]  av = ra[i*8 +: 8];
      sum += longint'(rv) * longint'(av);
    end
    return (sum * longint'(ir)) / BASE;
  endfunction

  function automatic longint exp_chg(input longint q);
`ifdef CROSS_COMM_SAT_EN
    if (q >= 65536) return 65535;
`endif
    return q % 65536;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input string tag, input logic [63:0] r,
                           input logic [31:0] ra, input logic [7:0] ir);
    int n = 0;
    m_if.outright_rate = r;
    m_if.ratio         = ra;
    m_if.inter_rate    = ir;
    m_if.in_valid      = 1'b1;
    while (!m_if.in_ready && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_accept"}, m_if.in_ready, 1);
    tick();
    m_if.in_valid      = 1'b0;
    m_if.outright_rate = {$urandom, $urandom};
    m_if.ratio         = $urandom;
    m_if.inter_rate    = 8'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!m_if.out_valid && lat < 200);
  endtask

  task automatic run_full(input string tag, input logic [63:0] r,
                          input logic [31:0] ra, input logic [7:0] ir);
    int lat;
    longint q = model_q(r, ra, ir);
    m_if.out_ready = 1'b1;
    start_req(tag, r, ra, ir);
    wait_out(lat);
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_chg"}, m_if.cross_comm_charge, exp_chg(q));
    chk({tag, "_ovf"}, m_if.overflow, q >= 65536);
    tick();
    chk({tag, "_vld_drop"}, m_if.out_valid, 0);
    chk({tag, "_rdy_back"}, m_if.in_ready, 1);
  endtask

  logic [63:0] basic_r  = {16'd0, 16'd0, 16'd2000, 16'd1000};
  logic [31:0] basic_ra = {8'd0, 8'd0, 8'd2, 8'd1};

  initial begin
    int lat;
    bit seen;
    reset = 1'b1;
    m_if.in_valid = 1'b0;
    m_if.out_ready = 1'b0;
    m_if.outright_rate = '0;
    m_if.ratio = '0;
    m_if.inter_rate = '0;
    s_if.in_valid = 1'b0;
    s_if.out_ready = 1'b0;
    s_if.outright_rate = '0;
    s_if.ratio = '0;
    s_if.inter_rate = '0;
    repeat (3) tick();
    chk("rst_vld", m_if.out_valid, 0);
    chk("rst_chg", m_if.cross_comm_charge, 0);
    chk("rst_ovf", m_if.overflow, 0);
    chk("rst_rdy", m_if.in_ready, 0);
    reset = 1'b0;
    #1;
    chk("rel_rdy", m_if.in_ready, 1);

    run_full("basic", basic_r, basic_ra, 8'd50);
    chk("basic_model", model_q(basic_r, basic_ra, 8'd50), 2500);
    run_full("trunc333", {48'd0, 16'd333}, {24'd0, 8'd1}, 8'd1);
    run_full("trunc199", {48'd0, 16'd199}, {24'd0, 8'd1}, 8'd1);
    run_full("ovf", {4{16'hFFFF}}, {4{8'hFF}}, 8'd255);

    // Backpressure with noisy inputs while the result is held
    m_if.out_ready = 1'b0;
    start_req("bp", basic_r, basic_ra, 8'd50);
    wait_out(lat);
    chk("bp_lat", lat, LAT);
    for (int i = 0; i < 10; i++) begin
      m_if.in_valid = 1'($urandom);
      m_if.outright_rate = {$urandom, $urandom};
      m_if.ratio = $urandom;
      m_if.inter_rate = 8'($urandom);
      tick();
      chk("bp_vld", m_if.out_valid, 1);
      chk("bp_chg", m_if.cross_comm_charge, 2500);
      chk("bp_ovf", m_if.overflow, 0);
      chk("bp_rdy", m_if.in_ready, 0);
    end
    m_if.in_valid = 1'b0;
    m_if.out_ready = 1'b1;
    tick();
    chk("bp_hs_vld", m_if.out_valid, 0);
    chk("bp_hs_rdy", m_if.in_ready, 1);
    seen = 1'b0;
    repeat (45) begin
      tick();
      if (m_if.out_valid || !m_if.in_ready) seen = 1'b1;
    end
    chk("bp_no_queue", seen, 0);

    // Reset during ACCUM leg 2
    start_req("mid", basic_r, basic_ra, 8'd50);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rdy", m_if.in_ready, 1);
    seen = 1'b0;
    repeat (60) begin
      tick();
      if (m_if.out_valid) seen = 1'b1;
    end
    chk("mid_no_vld", seen, 0);
    run_full("post_rst", basic_r, basic_ra, 8'd50);

    for (int k = 0; k < 20; k++) begin
      logic [63:0] r;
      logic [31:0] ra;
      logic [7:0] ir;
      for (int i = 0; i < 4; i++) begin
        r[i*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
        ra[i*8 +: 8]  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      end
      ir = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      run_full("rand", r, ra, ir);
    end

    // Single-leg instance, PCT_BASE=1000
    s_if.outright_rate = 16'd40000;
    s_if.ratio = 8'd3;
    s_if.inter_rate = 10'd10;
    s_if.out_ready = 1'b1;
    s_if.in_valid = 1'b1;
    chk("swp_rdy", s_if.in_ready, 1);
    tick();
    s_if.in_valid = 1'b0;
    s_if.outright_rate = 16'($urandom);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!s_if.out_valid && lat < 200);
    chk("swp_lat", lat, 36);
    chk("swp_chg", s_if.cross_comm_charge, (40000 * 3 * 10) / 1000);
    chk("swp_ovf", s_if.overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
